// File: rtl/punc_control.sv
// punc_control: multi-cycle FSM sequencer for the PUnC LC3 datapath.
// Fetches, decodes and executes one instruction at a time and drives every
// datapath select, write enable and PC control from (state, ir, n/z/p).
//
// State table:
//   state  | meaning
//   FETCH  | ir <= mem[PC], PC <= PC + 1
//   DECODE | settle cycle, all outputs 0
//   EXEC   | main execute cycle, selected by ir[15:12]
//   EXEC2  | second execute cycle for JSR/JSRR/LDI/STI
//   HALT   | sticky until rst, halted = 1
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ir[15:0], n, z, p        instruction register and condition flags
//   write_mem, write_ir, write_rf, write_status, ldi_ld, pc_ld, inc_pc  enables
//   jsr_s                    RF write address forced to R7
//   rf_s, mem_s              RF write data / memory address selects
//   rf_raddr0_s, rf_raddr1_s RF read address selects
//   alu_s[1:0], op1_s[1:0], op2_s[2:0]  ALU operation and operand selects
//   halted                   high in HALT
module punc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        write_mem,
  output logic        write_ir,
  output logic        write_rf,
  output logic        write_status,
  output logic        ldi_ld,
  output logic        pc_ld,
  output logic        inc_pc,
  output logic        jsr_s,
  output logic        rf_s,
  output logic        mem_s,
  output logic        rf_raddr0_s,
  output logic        rf_raddr1_s,
  output logic [1:0]  alu_s,
  output logic [1:0]  op1_s,
  output logic [2:0]  op2_s,
  output logic        halted
);

  localparam logic [1:0] ALU_ADD = 2'd0, ALU_AND = 2'd1, ALU_NOT = 2'd2, ALU_THRU = 2'd3;
  localparam logic [1:0] OP1_PC = 2'd0, OP1_RF0 = 2'd1, OP1_RF1 = 2'd2;
  localparam logic [2:0] OP2_SR2 = 3'd0, OP2_IMM5 = 3'd1, OP2_OFF6 = 3'd2,
                         OP2_OFF9 = 3'd3, OP2_OFF11 = 3'd4;

  localparam logic [3:0] OPC_BR  = 4'b0000, OPC_ADD = 4'b0001, OPC_LD  = 4'b0010,
                         OPC_ST  = 4'b0011, OPC_JSR = 4'b0100, OPC_AND = 4'b0101,
                         OPC_LDR = 4'b0110, OPC_STR = 4'b0111, OPC_NOT = 4'b1001,
                         OPC_LDI = 4'b1010, OPC_STI = 4'b1011, OPC_JMP = 4'b1100,
                         OPC_LEA = 4'b1110, OPC_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [3:0] opc;
  logic       br_taken;
  logic       unused_ir;

  assign opc       = ir[15:12];
  assign br_taken  = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  // Remaining ir fields are consumed directly by the datapath.
  assign unused_ir = ^{ir[8:6], ir[4:0]};

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (opc == OPC_JSR || opc == OPC_LDI || opc == OPC_STI) state_d = S_EXEC2;
        else if (opc == OPC_HLT)                                 state_d = S_HALT;
        else                                                     state_d = S_FETCH;
      end
      S_EXEC2:  state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    if (rst) state_d = S_FETCH;
  end

  always_comb begin
    write_mem = 1'b0; write_ir = 1'b0; write_rf = 1'b0; write_status = 1'b0;
    ldi_ld = 1'b0; pc_ld = 1'b0; inc_pc = 1'b0; jsr_s = 1'b0;
    rf_s = 1'b0; mem_s = 1'b0; rf_raddr0_s = 1'b0; rf_raddr1_s = 1'b0;
    alu_s = ALU_ADD; op1_s = OP1_PC; op2_s = OP2_SR2; halted = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        op1_s = OP1_PC; alu_s = ALU_THRU; mem_s = 1'b1;
        write_ir = 1'b1; inc_pc = 1'b1;
      end
      S_EXEC: begin
        case (opc)
          OPC_ADD, OPC_AND: begin
            op1_s = OP1_RF0;
            op2_s = ir[5] ? OP2_IMM5 : OP2_SR2;
            alu_s = (opc == OPC_ADD) ? ALU_ADD : ALU_AND;
            rf_s = 1'b1; write_rf = 1'b1; write_status = 1'b1;
          end
          OPC_NOT: begin
            op1_s = OP1_RF0; alu_s = ALU_NOT;
            rf_s = 1'b1; write_rf = 1'b1; write_status = 1'b1;
          end
          OPC_BR: begin
            if (br_taken) begin
              op1_s = OP1_PC; op2_s = OP2_OFF9; alu_s = ALU_ADD; pc_ld = 1'b1;
            end
          end
          OPC_JMP: begin
            rf_raddr1_s = 1'b1; op1_s = OP1_RF1; alu_s = ALU_THRU; pc_ld = 1'b1;
          end
          OPC_JSR: begin
            // Link first: R7 <= already-incremented PC.
            op1_s = OP1_PC; alu_s = ALU_THRU; rf_s = 1'b1; jsr_s = 1'b1; write_rf = 1'b1;
          end
          OPC_LD: begin
            op1_s = OP1_PC; op2_s = OP2_OFF9; alu_s = ALU_ADD; mem_s = 1'b1;
            write_rf = 1'b1; write_status = 1'b1;
          end
          OPC_LDR: begin
            op1_s = OP1_RF0; op2_s = OP2_OFF6; alu_s = ALU_ADD; mem_s = 1'b1;
            write_rf = 1'b1; write_status = 1'b1;
          end
          OPC_LEA: begin
            op1_s = OP1_PC; op2_s = OP2_OFF9; alu_s = ALU_ADD; rf_s = 1'b1; write_rf = 1'b1;
          end
          OPC_ST: begin
            op1_s = OP1_PC; op2_s = OP2_OFF9; alu_s = ALU_ADD; mem_s = 1'b1;
            rf_raddr0_s = 1'b1; write_mem = 1'b1;
          end
          OPC_STR: begin
            rf_raddr1_s = 1'b1; op1_s = OP1_RF1; op2_s = OP2_OFF6; alu_s = ALU_ADD;
            mem_s = 1'b1; rf_raddr0_s = 1'b1; write_mem = 1'b1;
          end
          OPC_LDI, OPC_STI: begin
            op1_s = OP1_PC; op2_s = OP2_OFF9; alu_s = ALU_ADD; mem_s = 1'b1; ldi_ld = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        case (opc)
          OPC_JSR: begin
            if (ir[11]) begin
              op1_s = OP1_PC; op2_s = OP2_OFF11; alu_s = ALU_ADD; pc_ld = 1'b1;
            end else begin
              // JSRR reads the base register after R7 was linked.
              rf_raddr1_s = 1'b1; op1_s = OP1_RF1; alu_s = ALU_THRU; pc_ld = 1'b1;
            end
          end
          OPC_LDI: begin
            mem_s = 1'b0; rf_s = 1'b0; write_rf = 1'b1; write_status = 1'b1;
          end
          OPC_STI: begin
            mem_s = 1'b0; rf_raddr0_s = 1'b1; write_mem = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase

    // Reset cycle: nothing may be written or selected.
    if (rst) begin
      write_mem = 1'b0; write_ir = 1'b0; write_rf = 1'b0; write_status = 1'b0;
      ldi_ld = 1'b0; pc_ld = 1'b0; inc_pc = 1'b0; jsr_s = 1'b0;
      rf_s = 1'b0; mem_s = 1'b0; rf_raddr0_s = 1'b0; rf_raddr1_s = 1'b0;
      alu_s = ALU_ADD; op1_s = OP1_PC; op2_s = OP2_SR2; halted = 1'b0;
    end
  end

endmodule

// File: tb/tb_punc_control.sv
// Directed bench for punc_control: walks each opcode through its states and
// compares the full packed output vector against hand-written expectations.
module tb_punc_control;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        n, z, p;
  logic        write_mem, write_ir, write_rf, write_status, ldi_ld, pc_ld, inc_pc;
  logic        jsr_s, rf_s, mem_s, rf_raddr0_s, rf_raddr1_s, halted;
  logic [1:0]  alu_s, op1_s;
  logic [2:0]  op2_s;

  int total = 0;
  int bad = 0;

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .write_mem(write_mem), .write_ir(write_ir), .write_rf(write_rf),
    .write_status(write_status), .ldi_ld(ldi_ld), .pc_ld(pc_ld), .inc_pc(inc_pc),
    .jsr_s(jsr_s), .rf_s(rf_s), .mem_s(mem_s), .rf_raddr0_s(rf_raddr0_s),
    .rf_raddr1_s(rf_raddr1_s), .alu_s(alu_s), .op1_s(op1_s), .op2_s(op2_s),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Packed layout: wm wir wrf wst ldi pcld inc jsr rfs mems r0 r1 alu[2] op1[2] op2[3] halted
  localparam logic [19:0] WM = 20'h80000, WIR = 20'h40000, WRF = 20'h20000, WST = 20'h10000;
  localparam logic [19:0] LDI = 20'h08000, PCL = 20'h04000, INC = 20'h02000, JSR = 20'h01000;
  localparam logic [19:0] RFS = 20'h00800, MEMS = 20'h00400, R0S = 20'h00200, R1S = 20'h00100;
  localparam logic [19:0] HLT = 20'h00001;

  function automatic logic [19:0] alu(input int v); return 20'(v) << 6; endfunction
  function automatic logic [19:0] op1(input int v); return 20'(v) << 4; endfunction
  function automatic logic [19:0] op2(input int v); return 20'(v) << 1; endfunction

  logic [19:0] obs;
  assign obs = {write_mem, write_ir, write_rf, write_status, ldi_ld, pc_ld, inc_pc,
                jsr_s, rf_s, mem_s, rf_raddr0_s, rf_raddr1_s, alu_s, op1_s, op2_s, halted};

  logic [19:0] E_FETCH;
  assign E_FETCH = op1(0) | alu(3) | MEMS | WIR | INC;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [19:0] exp);
    #1;
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Entered in FETCH; leaves the DUT in the following FETCH.
  task automatic instr(input string tag, input logic [15:0] code,
                       input logic [19:0] e_exec, input bit two, input logic [19:0] e_exec2);
    check({tag, "/fetch"}, E_FETCH);
    tick(); ir = code;
    check({tag, "/decode"}, 20'h0);
    tick();
    check({tag, "/exec"}, e_exec);
    if (two) begin
      tick();
      check({tag, "/exec2"}, e_exec2);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; ir = 16'h0; n = 1'b0; z = 1'b0; p = 1'b0;
    tick(); tick();
    check("reset_outputs_zero", 20'h0);
    rst = 1'b0;

    p = 1'b1;
    instr("add_imm", 16'h1225, op1(1) | op2(1) | alu(0) | RFS | WRF | WST, 0, 0);
    instr("add_reg", 16'h1042, op1(1) | op2(0) | alu(0) | RFS | WRF | WST, 0, 0);
    instr("and_imm", 16'h5265, op1(1) | op2(1) | alu(1) | RFS | WRF | WST, 0, 0);
    instr("not",     16'h927F, op1(1) | alu(2) | RFS | WRF | WST, 0, 0);

    n = 1'b0; z = 1'b1; p = 1'b0;
    instr("brz_taken",   16'h0404, op1(0) | op2(3) | alu(0) | PCL, 0, 0);
    n = 1'b1; z = 1'b0; p = 1'b1;
    instr("brz_not",     16'h0404, 20'h0, 0, 0);
    instr("brn_taken",   16'h0804, op1(0) | op2(3) | alu(0) | PCL, 0, 0);
    n = 1'b1; z = 1'b1; p = 1'b1;
    instr("br_mask0",    16'h0004, 20'h0, 0, 0);
    n = 1'b0; z = 1'b0; p = 1'b1;

    instr("jsr",  16'h4802, op1(0) | alu(3) | RFS | JSR | WRF, 1, op1(0) | op2(4) | alu(0) | PCL);
    instr("jsrr", 16'h40C0, op1(0) | alu(3) | RFS | JSR | WRF, 1, R1S | op1(2) | alu(3) | PCL);
    instr("jmp",  16'hC1C0, R1S | op1(2) | alu(3) | PCL, 0, 0);

    instr("ld",  16'h2203, op1(0) | op2(3) | alu(0) | MEMS | WRF | WST, 0, 0);
    instr("ldr", 16'h6283, op1(1) | op2(2) | alu(0) | MEMS | WRF | WST, 0, 0);
    instr("lea", 16'hE203, op1(0) | op2(3) | alu(0) | RFS | WRF, 0, 0);
    instr("st",  16'h3403, op1(0) | op2(3) | alu(0) | MEMS | R0S | WM, 0, 0);
    instr("str", 16'h7483, R1S | op1(2) | op2(2) | alu(0) | MEMS | R0S | WM, 0, 0);
    instr("ldi", 16'hA203, op1(0) | op2(3) | alu(0) | MEMS | LDI, 1, WRF | WST);
    instr("sti", 16'hB403, op1(0) | op2(3) | alu(0) | MEMS | LDI, 1, R0S | WM);
    instr("nop_8", 16'h8000, 20'h0, 0, 0);
    instr("nop_d", 16'hD000, 20'h0, 0, 0);

    // Reset during EXEC of ST: store must be suppressed, then restart at FETCH.
    check("st_rst/fetch", E_FETCH);
    tick(); ir = 16'h3403;
    tick(); rst = 1'b1;
    check("st_rst/exec_forced0", 20'h0);
    tick(); rst = 1'b0;
    check("st_rst/refetch", E_FETCH);

    // HALT is sticky regardless of ir/flags; only rst leaves it.
    tick(); ir = 16'hF025;
    tick();
    check("halt/exec", 20'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      ir = 16'h3403; n = i[0]; z = i[1]; p = 1'b1;
      check($sformatf("halt/hold%0d", i), HLT);
    end
    rst = 1'b1;
    check("halt/rst_forced0", 20'h0);
    tick(); rst = 1'b0;
    check("halt/after_rst_fetch", E_FETCH);
    tick();
    check("halt/after_rst_decode", 20'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
